// File: rtl/int_ctrl_if.sv
// CPU-side bus bundle for the interrupt controller: status/strobe inputs
// from the i8080 and the request/vector outputs back toward it.
interface int_ctrl_if #(
  parameter int XLEN = 8
);
  logic            sync;
  logic            dbin;
  logic            inte;
  logic [XLEN-1:0] data_in;
  logic            iint;
  logic            vec_oe;
  logic [XLEN-1:0] vec_data;

  modport master (
    output sync, dbin, inte, data_in,
    input  iint, vec_oe, vec_data
  );

  modport slave (
    input  sync, dbin, inte, data_in,
    output iint, vec_oe, vec_data
  );
endinterface

// File: rtl/int_ctrl.sv
// Two-source interrupt controller for the i8080 system. Latches mid-screen
// and vertical-blank events, requests an interrupt while the CPU has them
// enabled, and supplies the matching RST opcode during the INTA fetch.
module int_ctrl #(
  parameter int              XLEN        = 8,
  parameter logic [XLEN-1:0] VEC_MID     = 8'hCF,
  parameter logic [XLEN-1:0] VEC_VBL     = 8'hD7,
  parameter int              STATUS_INTA = 0
) (
  input  logic       clk,
  input  logic       rst,
  int_ctrl_if.slave  bus,
  input  logic       irq_mid,
  input  logic       irq_vbl,
  output logic [7:0] overrun
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACK_WAIT  = 2'd1,
    ACK_DRIVE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       sel;
  logic       pend_mid;
  logic       pend_vbl;
  logic       inta_sync;
  logic       other_sync;
  logic       clr_mid;
  logic       clr_vbl;
  logic       lost_mid;
  logic       lost_vbl;
  logic [1:0] lost_cnt;
  logic [8:0] ovr_sum;

  // Decode the status byte and work out which pending bit an INTA capture
  // consumes (VBL first); a spurious INTA consumes nothing.
  always_comb begin
    inta_sync  = bus.sync & bus.data_in[STATUS_INTA];
    other_sync = bus.sync & ~bus.data_in[STATUS_INTA];
    clr_vbl    = inta_sync & pend_vbl;
    clr_mid    = inta_sync & ~pend_vbl & pend_mid;
    lost_vbl   = irq_vbl & pend_vbl & ~clr_vbl;
    lost_mid   = irq_mid & pend_mid & ~clr_mid;
    lost_cnt   = {1'b0, lost_vbl} + {1'b0, lost_mid};
    ovr_sum    = {1'b0, overrun} + {7'b0, lost_cnt};
  end

  // Acknowledge state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Acknowledge sequencing: any INTA sync (re)starts a capture, a non-INTA
  // sync aborts, otherwise follow the DBIN window.
  always_comb begin
    state_next = state;
    if (inta_sync) begin
      state_next = ACK_WAIT;
    end else if (other_sync) begin
      state_next = IDLE;
    end else begin
      case (state)
        ACK_WAIT:  if (bus.dbin)  state_next = ACK_DRIVE;
        ACK_DRIVE: if (!bus.dbin) state_next = IDLE;
        default:   state_next = IDLE;
      endcase
    end
  end

  // Pending bits, source select, registered request and overrun counter;
  // a new pulse beats a same-cycle acknowledge clear of that source.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_mid <= 1'b0;
      pend_vbl <= 1'b0;
      sel      <= 1'b0;
      bus.iint <= 1'b0;
      overrun  <= 8'd0;
    end else begin
      pend_mid <= irq_mid | (pend_mid & ~clr_mid);
      pend_vbl <= irq_vbl | (pend_vbl & ~clr_vbl);
      if (inta_sync) begin
        sel <= pend_vbl;
      end
      bus.iint <= bus.inte & (pend_mid | pend_vbl);
      overrun  <= ovr_sum[8] ? 8'hFF : ovr_sum[7:0];
    end
  end

  // Vector bus drive follows DBIN directly so the opcode covers the whole
  // read window; the opcode itself is held for the full acknowledge.
  always_comb begin
    bus.vec_oe   = ((state == ACK_WAIT) | (state == ACK_DRIVE)) & bus.dbin;
    bus.vec_data = '0;
    if (state != IDLE) begin
      bus.vec_data = sel ? VEC_VBL : VEC_MID;
    end
  end

endmodule
